synclk_monitor: RTL
===================

// Module: synclk_monitor
// PURPOSE
// - Consumes the per-lane activity toggles from the differential clock loopback lanes (synclk_p/n).
//   Each rx clock domain drives a divided toggle; this block brings the toggles into clk (40 MHz).
// - Counts toggle transitions per fixed window of clk cycles and range-checks each lane's rate.
// - Produces per-lane counts, ok/fail flags and status LEDs in place of raw counter-bit blinking.
// PARAMETERS
// NLANE      4          number of monitored lanes
// WINDOW     4000000    measurement window length in clk cycles (100 ms at 40 MHz); >= 2
// CNT_W      24         width of each lane edge counter
// MIN_EDGES  90000      lowest per-window edge count that passes (inclusive)
// MAX_EDGES  110000     highest per-window edge count that passes (inclusive)
// PORTS
// clk           in   1            system clock, 40 MHz; sole clock of the block
// reset         in   1            synchronous, active-high reset
// lane_tog      in   NLANE        asynchronous per-lane toggles from rx clock domains
// lane_count    out  NLANE*CNT_W  last completed window's edge count; lane i at [i*CNT_W +: CNT_W]
// lane_ok       out  NLANE        lane i count within [MIN_EDGES, MAX_EDGES] in last window
// lane_fail     out  NLANE        sticky: lane i failed in any window since reset
// sample_valid  out  1            one-cycle pulse when lane_count/lane_ok update
// led           out  NLANE        lane_ok[i] ? heartbeat : 0; heartbeat toggles each window
// BEHAVIOUR
// - Reset: lane_count, lane_ok, lane_fail, sample_valid, led, heartbeat = 0.
//   Window counter = 0, accumulators = 0, FSM = WARMUP. Reset mid-window discards all progress.
// - Input capture, per lane:
//   - 2-FF synchronizer s1->s2, then history FF s3; edge = s2 ^ s3.
//   - Both toggle directions count.
//   - Latency: lane_tog transition to accumulator increment = 3 clk cycles.
// - Window counter: runs 0..WINDOW-1, wraps to 0. The cycle where it equals WINDOW-1 is the terminal cycle.
// - Accumulators:
//   - Add 1 per edge cycle.
//   - Saturate at 2^CNT_W-1; they never wrap.
//   - At the terminal cycle they reload to 1 if an edge occurs that cycle, else 0.
//     That terminal-cycle edge is credited to the new window, not the closing one.
// - FSM:
//   - WARMUP: first window after reset. Results are discarded while the synchronizers settle.
//     Outputs keep their reset values. At the terminal cycle -> RUN.
//   - RUN: at each terminal cycle, on the next edge:
//     - lane_count <= accumulator value for the closing window;
//     - lane_ok[i] <= MIN_EDGES <= count <= MAX_EDGES;
//     - lane_fail[i] <= lane_fail[i] | ~ok;
//     - heartbeat toggles;
//     - sample_valid = 1 for exactly that one cycle.
//   - RUN persists until reset.
// - Outputs are registered. lane_count/lane_ok/lane_fail are stable between sample_valid pulses.
// - led is registered from lane_ok & heartbeat. A failed lane's LED is dark; a passing lane blinks at 1/(2*WINDOW).
// - Comparisons are unsigned at CNT_W bits. MIN_EDGES <= MAX_EDGES < 2^CNT_W is required; an elaboration check enforces it.
// TESTING
// Bench params: WINDOW=1000, CNT_W=12, MIN_EDGES=90, MAX_EDGES=110, NLANE=4.
// - Lane 0 toggles every 10 clk. After WARMUP + 1 window:
//   sample_valid pulses, lane_count[0]=100, lane_ok[0]=1, lane_fail[0]=0, led[0] follows heartbeat.
// - Lane 1 held constant:
//   lane_count[1]=0, lane_ok[1]=0, lane_fail[1]=1, led[1]=0.
//   Restart toggling every 10 clk -> lane_ok[1]=1 next window; lane_fail[1] stays 1.
// - Lane 2 toggles every 2 clk:
//   lane_count[2]=500, lane_ok[2]=0, lane_fail[2]=1.
// - CNT_W=8, lane toggles every clk:
//   lane_count=255 (saturated), no wrap, lane_ok=0.
// - Single toggle timed so its edge lands on the terminal cycle:
//   closing window count excludes it, next window includes it (counts 0 then 1).
// - reset asserted at window cycle 500:
//   all outputs 0 next cycle; no sample_valid until a full WARMUP plus a full RUN window have elapsed.

Source files
------------

// File: rtl/synclk_monitor.sv
// synclk_monitor
//   Brings the per-lane activity toggles from the rx clock loopback lanes into
//   the clk domain. Each toggle transition is counted over a fixed window of
//   clk cycles, and each lane's count is range-checked once per window. The
//   results drive per-lane ok/fail flags and status LEDs.
//
// Ports
//   clk           system clock (40 MHz); the only clock in this block
//   reset         synchronous, active-high reset
//   lane_tog      asynchronous per-lane toggles from the rx clock domains
//   lane_count    edge count of the last completed window; lane i at [i*CNT_W +: CNT_W]
//   lane_ok       lane i count was within [MIN_EDGES, MAX_EDGES] in the last window
//   lane_fail     sticky: lane i has failed in some window since reset
//   sample_valid  one-cycle pulse when lane_count/lane_ok update
//   led           lane_ok & heartbeat; the heartbeat toggles once per window
module synclk_monitor #(
  parameter int NLANE     = 4,
  parameter int WINDOW    = 4000000,
  parameter int CNT_W     = 24,
  parameter int MIN_EDGES = 90000,
  parameter int MAX_EDGES = 110000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NLANE-1:0]       lane_tog,
  output logic [NLANE*CNT_W-1:0] lane_count,
  output logic [NLANE-1:0]       lane_ok,
  output logic [NLANE-1:0]       lane_fail,
  output logic                   sample_valid,
  output logic [NLANE-1:0]       led
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_EDGES);

  // Thresholds must be ordered and representable at CNT_W bits.
  if ((MIN_EDGES < 0) || (MIN_EDGES > MAX_EDGES) ||
      ((64'(MAX_EDGES) >> CNT_W) != 64'd0) || (WINDOW < 2)) begin : g_param_check
    $error("synclk_monitor: need 0 <= MIN_EDGES <= MAX_EDGES < 2**CNT_W and WINDOW >= 2");
  end

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     capture_s;
  logic                     terminal_s;
  logic [WIN_W-1:0]         win_cnt_r;
  logic [NLANE-1:0]         sync1_r;
  logic [NLANE-1:0]         sync2_r;
  logic [NLANE-1:0]         hist_r;
  logic [NLANE-1:0]         edge_s;
  logic [CNT_W-1:0]         acc_r     [NLANE];
  logic [CNT_W-1:0]         acc_nxt_s [NLANE];
  logic [NLANE-1:0]         ok_s;
  logic [NLANE*CNT_W-1:0]   count_pack_s;
  logic [NLANE*CNT_W-1:0]   count_r;
  logic [NLANE-1:0]         ok_r;
  logic [NLANE-1:0]         fail_r;
  logic                     valid_r;
  logic                     hb_r;
  logic [NLANE-1:0]         led_r;

  // Both toggle directions are edges: a change between s2 and its history copy.
  assign edge_s     = sync2_r ^ hist_r;
  assign terminal_s = (win_cnt_r == WIN_LAST);

  // Two-flop synchronizer plus one history flop per lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {NLANE{1'b0}};
      sync2_r <= {NLANE{1'b0}};
      hist_r  <= {NLANE{1'b0}};
    end else begin
      sync1_r <= lane_tog;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Free-running window counter, 0..WINDOW-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_r <= WIN_ZERO;
    end else if (terminal_s) begin
      win_cnt_r <= WIN_ZERO;
    end else begin
      win_cnt_r <= win_cnt_r + WIN_ONE;
    end
  end

  // Accumulator next value: saturating count, and at the terminal cycle
  // restart with that cycle's edge credited to the new window.
  always_comb begin
    for (int i = 0; i < NLANE; i++) begin
      acc_nxt_s[i] = acc_r[i];
      if (terminal_s) begin
        acc_nxt_s[i] = edge_s[i] ? CNT_ONE : CNT_ZERO;
      end else if (edge_s[i] && (acc_r[i] != CNT_MAX)) begin
        acc_nxt_s[i] = acc_r[i] + CNT_ONE;
      end else begin
        acc_nxt_s[i] = acc_r[i];
      end
    end
  end

  // Per-lane accumulator registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (reset) begin
        acc_r[i] <= CNT_ZERO;
      end else begin
        acc_r[i] <= acc_nxt_s[i];
      end
    end
  end

  // Range check and packing of the closing window's counts.
  always_comb begin
    ok_s         = {NLANE{1'b0}};
    count_pack_s = {(NLANE*CNT_W){1'b0}};
    for (int i = 0; i < NLANE; i++) begin
      ok_s[i] = (acc_r[i] >= MIN_C) && (acc_r[i] <= MAX_C);
      count_pack_s[i*CNT_W +: CNT_W] = acc_r[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_WARMUP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; the first window after reset only lets the synchronizers settle.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_WARMUP: begin
        if (terminal_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        capture_s   = terminal_s;
      end
      default: begin
        state_nxt_s = ST_WARMUP;
        capture_s   = 1'b0;
      end
    endcase
  end

  // Result registers, updated once per completed RUN window.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {(NLANE*CNT_W){1'b0}};
      ok_r    <= {NLANE{1'b0}};
      fail_r  <= {NLANE{1'b0}};
      valid_r <= 1'b0;
      hb_r    <= 1'b0;
      led_r   <= {NLANE{1'b0}};
    end else begin
      valid_r <= capture_s;
      led_r   <= ok_r & {NLANE{hb_r}};
      if (capture_s) begin
        count_r <= count_pack_s;
        ok_r    <= ok_s;
        fail_r  <= fail_r | ~ok_s;
        hb_r    <= ~hb_r;
      end
    end
  end

  assign lane_count   = count_r;
  assign lane_ok      = ok_r;
  assign lane_fail    = fail_r;
  assign sample_valid = valid_r;
  assign led          = led_r;

endmodule
